// File: rtl/interrupt_ctrl.sv
// Interrupt request/enable unit: edge-latched IF (0xFF0F), IE (0xFFFF), prioritised irq/vector with ack.
// Define INTC_IRQ_REG_EN to register irq/vector (one extra cycle of latency).
module interrupt_ctrl (
    input  logic       clk,
    input  logic       n_reset2,
    input  logic       int_vblank,
    input  logic       int_stat,
    input  logic       int_timer,
    input  logic       int_serial,
    input  logic       int_joypad,
    input  logic [7:0] d_in,
    input  logic       if_write,
    input  logic       ie_write,
    input  logic       if_read,
    input  logic       ie_read,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic       int_ack,
    output logic       irq,
    output logic [7:0] vector
);

    function automatic logic [7:0] prio_vector(input logic [4:0] pend);
        logic [7:0] v;
        casez (pend)
            5'b????1: v = 8'h40;
            5'b???10: v = 8'h48;
            5'b??100: v = 8'h50;
            5'b?1000: v = 8'h58;
            5'b10000: v = 8'h60;
            default:  v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [4:0] vector_bit(input logic [7:0] vec);
        logic [4:0] b;
        case (vec)
            8'h40:   b = 5'b00001;
            8'h48:   b = 5'b00010;
            8'h50:   b = 5'b00100;
            8'h58:   b = 5'b01000;
            8'h60:   b = 5'b10000;
            default: b = 5'b00000;
        endcase
        return b;
    endfunction

    logic [4:0] src_s;
    logic [4:0] prev_r;
    logic [4:0] edge_s;
    logic [4:0] if_r;
    logic [7:0] ie_r;
    logic [4:0] pend_s;
    logic [4:0] ack_mask_s;
    logic [4:0] if_next_s;
    logic       irq_s;
    logic [7:0] vector_s;

    assign src_s  = {int_joypad, int_serial, int_timer, int_stat, int_vblank};
    assign edge_s = src_s & ~prev_r;
    assign pend_s = if_r & ie_r[4:0];

`ifdef INTC_IRQ_REG_EN
    logic       irq_r;
    logic [7:0] vector_r;

    // Registered request copy; dropped on the ack edge so a stale vector never follows an ack.
    always_ff @(posedge clk or negedge n_reset2) begin
        if (!n_reset2) begin
            irq_r    <= 1'b0;
            vector_r <= 8'h00;
        end else if (int_ack) begin
            irq_r    <= 1'b0;
            vector_r <= 8'h00;
        end else begin
            irq_r    <= |pend_s;
            vector_r <= prio_vector(pend_s);
        end
    end

    // Presented request comes from the registered copy.
    always_comb begin
        irq_s    = irq_r;
        vector_s = vector_r;
    end
`else
    // Presented request is combinational from IF/IE.
    always_comb begin
        irq_s    = |pend_s;
        vector_s = prio_vector(pend_s);
    end
`endif

    assign irq    = irq_s;
    assign vector = vector_s;

    // IF next state: write value beats ack, a new hardware edge beats both.
    always_comb begin
        ack_mask_s = 5'b00000;
        if (int_ack && irq_s) begin
            ack_mask_s = vector_bit(vector_s);
        end else begin
            ack_mask_s = 5'b00000;
        end
        if (if_write) begin
            if_next_s = d_in[4:0] | edge_s;
        end else begin
            if_next_s = (if_r & ~ack_mask_s) | edge_s;
        end
    end

    // Source history, IF and IE storage.
    always_ff @(posedge clk or negedge n_reset2) begin
        if (!n_reset2) begin
            prev_r <= 5'b00000;
            if_r   <= 5'b00000;
            ie_r   <= 8'h00;
        end else begin
            prev_r <= src_s;
            if_r   <= if_next_s;
            if (ie_write) begin
                ie_r <= d_in;
            end
        end
    end

    // Read mux; both selects together OR the values (illegal use, still defined).
    always_comb begin
        case ({if_read, ie_read})
            2'b10:   d_out = {3'b111, if_r};
            2'b01:   d_out = ie_r;
            2'b11:   d_out = {3'b111, if_r} | ie_r;
            default: d_out = 8'h00;
        endcase
    end

    assign d_oe = if_read | ie_read;

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Interrupt request/enable unit that consumes the serial block's `int_serial` pulse together with the other four SoC interrupt sources (VBlank, STAT, timer, joypad). It latches rising edges into the IF register (0xFF0F) and holds the IE register (0xFFFF). It presents a prioritised request and vector to the CPU core, and clears the serviced IF bit on CPU acknowledge.

## Interface
Parameters:
- none

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state changes on rising edge.
- `n_reset2`  in  1  asynchronous active-low reset.
- `int_vblank`, `int_stat`, `int_timer`, `int_serial`, `int_joypad`  in  1 each  request sources; level or pulse, at least 1 `clk` wide, synchronous to `clk`.
- `d_in`  in  8  CPU write data.
- `if_write`, `ie_write`  in  1 each  one-cycle write strobes for 0xFF0F / 0xFFFF.
- `if_read`, `ie_read`  in  1 each  read selects for 0xFF0F / 0xFFFF.
- `d_out`  out  8  read data; 0x00 when no read select is active.
- `d_oe`  out  1  `if_read | ie_read`.
- `int_ack`  in  1  one-cycle CPU acknowledge of the currently presented vector.
- `irq`  out  1  high while `(IF & IE[4:0]) != 0`.
- `vector`  out  8  0x40 + 8*n for the highest-priority pending enabled source n; 0x00 when `irq` is low.

## Operation
- Source index and priority: 0 VBlank > 1 STAT > 2 timer > 3 serial > 4 joypad.
- Edge detect:
  - Each source has a `prev` flop, reset 0.
  - `src & ~prev` sets `IF[n]` on the next edge.
  - A source held high across reset release sets its IF bit on the first clock.
- IF register:
  - 5 stored bits.
  - Read returns `{3'b111, IF[4:0]}`.
  - `if_write` loads `d_in[4:0]`; `d_in[7:5]` is ignored.
- IE register:
  - All 8 bits are stored and read back verbatim.
  - Only `IE[4:0]` gate requests.
- Pending: `pend = IF & IE[4:0]`. `irq = |pend`. `vector` is the priority encode of `pend`.
- Acknowledge: `int_ack` clears the IF bit of the vector presented in that cycle. If `irq` is low, the ack has no effect.
- Simultaneous events, same cycle, same bit:
  - edge + `if_write` with 0 → bit set (hardware wins).
  - edge + `int_ack` → bit stays set.
  - `if_write` + `int_ack` → write value wins; ack ignored.
- `ie_write` together with `int_ack`: the ack uses the `vector` as presented before the write.
- Reading both `if_read` and `ie_read` together returns the OR of both values. This is illegal bus use and is flagged by a bench assertion.

## Timing
- Reset values: IF=0, IE=0x00, `prev`=0, `irq`=0, `vector`=0x00, `d_out`=0x00, `d_oe`=0.
- Reset is asynchronous. Asserting it mid-request clears all state immediately. Outputs return to reset values without waiting for a clock.
- Source edge at cycle t → IF bit set after edge t+1.
- `irq`/`vector`: combinational from IF/IE (0 extra cycles) by default; see Configuration.
- Register writes take effect at the clock edge of the strobe.
- Reads are combinational from current register state, so a read in the same cycle as a write returns the old value.
- `int_ack` clears the bit at the strobe edge. The next pending source is presented in the following cycle.

## Configuration
- `INTC_IRQ_REG_EN`
- Defined:
  - `irq` and `vector` are registered, adding 1 cycle of latency (edge → `irq` = 2 cycles).
  - The registered copy is cleared in the same edge as `int_ack`, so a stale vector never follows an ack.
  - The ack still clears the IF bit matching the registered `vector`.
- Undefined: `irq`/`vector` are combinational as specified above.

## Test plan
- Reset: hold `n_reset2`=0, then release → IF read 0xE0, IE read 0x00, `irq`=0, `vector`=0x00.
- Serial request:
  - Write IE=0x08, pulse `int_serial` 1 cycle → IF read 0xE8, `irq`=1, `vector`=0x58.
  - Pulse `int_ack` → IF 0xE0, `irq`=0.
- Priority:
  - Write IE=0x1F, IF=0x18 → `vector`=0x58.
  - Raise `int_vblank` → `vector`=0x40 after 1 cycle.
  - Ack → `vector`=0x58.
- Collision:
  - `if_write` 0x00 in the same cycle as a `int_timer` rising edge → IF=0xE4.
  - `int_ack` on timer concurrent with a new timer edge → IF stays 0xE4.
- Level source: hold `int_stat` high for 10 cycles, write IF=0 mid-way → bit not re-set until `int_stat` falls and rises again.
- Async reset mid-operation: pulse `n_reset2` low between clock edges with IF=0x1F, IE=0xFF → `irq`=0 and IF=0xE0 immediately, no clock needed.
